// File: rtl/j68_div_32_if.sv
// rtl/j68_div_32_if.sv - request/response bundle between microcode datapath and the 32/16 divider
interface j68_div_32_if;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        overflow;
  logic [31:0] result;

  modport master (
    output start, signed_div, dividend, divisor,
    input  busy, done, div_zero, overflow, result
  );

  modport slave (
    input  start, signed_div, dividend, divisor,
    output busy, done, div_zero, overflow, result
  );
endinterface

// File: rtl/j68_div_32.sv
// rtl/j68_div_32.sv - multi-cycle restoring 32/16 divider with MC68000 DIVU/DIVS semantics
module j68_div_32 (
  input  logic          clk,
  input  logic          rst_n,
  j68_div_32_if.slave   bus
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ITER  = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic        sgn_q;
  logic [31:0] dvd_q;
  logic [15:0] dvs_q;
  logic [15:0] dvs_mag_q;
  logic [16:0] rem_q;
  logic [15:0] quo_q;
  logic        div_zero_q;
  logic        overflow_q;
  logic [31:0] result_q;

  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic [16:0] shifted;
  logic [17:0] diff;
  logic        q_neg;
  logic        fix_ovf;
  logic [15:0] quo_s;
  logic [15:0] rem_s;

  always_comb begin
    dvd_mag = dvd_q;
    dvs_mag = dvs_q;
    if (sgn_q && dvd_q[31]) dvd_mag = 32'd0 - dvd_q;
    if (sgn_q && dvs_q[15]) dvs_mag = 16'd0 - dvs_q;
  end

  // Partial remainder is always below the divisor, so bit 16 of rem_q is zero on entry.
  always_comb begin
    shifted = {rem_q[15:0], quo_q[15]};
    diff    = {1'b0, shifted} - {2'b00, dvs_mag_q};
  end

  always_comb begin
    q_neg   = dvd_q[31] ^ dvs_q[15];
    fix_ovf = q_neg ? (quo_q > 16'h8000) : (quo_q > 16'h7fff);
    quo_s   = q_neg ? (16'd0 - quo_q) : quo_q;
    rem_s   = dvd_q[31] ? (16'd0 - rem_q[15:0]) : rem_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      sgn_q      <= 1'b0;
      dvd_q      <= 32'd0;
      dvs_q      <= 16'd0;
      dvs_mag_q  <= 16'd0;
      rem_q      <= 17'd0;
      quo_q      <= 16'd0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // A start in the done cycle is accepted so back-to-back ops lose no cycle.
          if (bus.start) begin
            sgn_q      <= bus.signed_div;
            dvd_q      <= bus.dividend;
            dvs_q      <= bus.divisor;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            state      <= ST_CHECK;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (dvs_q == 16'd0) begin
            div_zero_q <= 1'b1;
            result_q   <= dvd_q;
            state      <= ST_DONE;
          end else if (dvd_mag[31:16] >= dvs_mag) begin
            overflow_q <= 1'b1;
            result_q   <= dvd_q;
            state      <= ST_DONE;
          end else begin
            rem_q     <= {1'b0, dvd_mag[31:16]};
            quo_q     <= dvd_mag[15:0];
            dvs_mag_q <= dvs_mag;
            cnt       <= 4'd0;
            state     <= ST_ITER;
          end
        end
        ST_ITER: begin
          // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom.
          if (!diff[17]) rem_q <= diff[16:0];
          else           rem_q <= shifted;
          quo_q <= {quo_q[14:0], ~diff[17]};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd15) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!sgn_q) begin
            result_q <= {rem_q[15:0], quo_q};
          end else if (fix_ovf) begin
            overflow_q <= 1'b1;
            result_q   <= dvd_q;
          end else begin
            result_q <= {rem_s, quo_s};
          end
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == ST_CHECK) || (state == ST_ITER) || (state == ST_FIX);
  assign bus.done     = (state == ST_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.overflow = overflow_q;
  assign bus.result   = result_q;
endmodule

// File: tb/tb_j68_div_32.sv
// tb/tb_j68_div_32.sv - directed bench for j68_div_32 covering DIVU/DIVS, early exits, back-to-back and reset
module tb_j68_div_32;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  j68_div_32_if bus ();

  j68_div_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request in cycle 0; returns at the negedge of cycle 1.
  task automatic launch(input logic sd, input logic [31:0] dvd, input logic [15:0] dvs);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.dividend   = dvd;
    bus.divisor    = dvs;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.dividend   = 32'hdead_beef;
    bus.divisor    = 16'hbeef;
    cyc = 1;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                           input logic exp_dz, input logic exp_ov);
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
    check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ov});
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd0;
    bus.divisor    = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
    rst_n = 1'b1;

    launch(1'b0, 32'h0001_86a0, 16'h0007);
    check("divu_busy_c1", {31'd0, bus.busy}, 32'd1);
    wait_done("divu_100000_7", 19, 32'h0005_37cd, 1'b0, 1'b0);

    launch(1'b0, 32'h1234_5678, 16'h0000);
    wait_done("divu_zero", 2, 32'h1234_5678, 1'b1, 1'b0);
    @(negedge clk);
    check("div_zero_held", {31'd0, bus.div_zero}, 32'd1);

    launch(1'b0, 32'h0010_0000, 16'h0010);
    wait_done("divu_check_ovf", 2, 32'h0010_0000, 1'b0, 1'b1);

    launch(1'b1, 32'hffff_fff9, 16'h0002);
    wait_done("divs_m7_2", 19, 32'hffff_fffd, 1'b0, 1'b0);

    launch(1'b1, 32'hffff_8000, 16'h0001);
    wait_done("divs_m32768_1", 19, 32'h0000_8000, 1'b0, 1'b0);

    launch(1'b1, 32'h0000_8000, 16'h0001);
    wait_done("divs_fix_ovf", 19, 32'h0000_8000, 1'b0, 1'b1);

    launch(1'b1, 32'h8000_0000, 16'h8000);
    wait_done("divs_min_dvd", 2, 32'h8000_0000, 1'b0, 1'b1);

    launch(1'b1, 32'h0000_0064, 16'hfff9);
    wait_done("divs_100_m7", 19, 32'h0002_fff2, 1'b0, 1'b0);

    launch(1'b0, 32'd1000, 16'd3);
    repeat (4) begin
      @(negedge clk);
      cyc++;
    end
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 16'd5;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
    wait_done("divu_ignore_start", 19, 32'h0001_014d, 1'b0, 1'b0);

    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd50;
    bus.divisor    = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("b2b_busy_c1", {31'd0, bus.busy}, 32'd1);
    wait_done("divu_back_to_back", 19, 32'h0000_000a, 1'b0, 1'b0);

    launch(1'b0, 32'd1000, 16'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) cyc++;
    end
    check("midrst_no_done", 32'(cyc), 32'd0);

    launch(1'b0, 32'd9, 16'd3);
    wait_done("divu_9_3", 19, 32'h0000_0003, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
